multi_queue_credit: RTL and testbench
=====================================

MULTI_QUEUE_CREDIT -- requirements
Module: multi_queue_credit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: entry width in bits.
REQ-002 Parameter DEPTH, default 16: total entry capacity; power of two, at least 4.
REQ-003 Parameter PUSH_CHANNEL, default 4: maximum entries pushed per cycle; at most DEPTH.
REQ-004 Parameter POP_CHANNEL, default 4: maximum entries popped per cycle and head window width; at most DEPTH.
REQ-005 Derived widths: CW = $clog2(DEPTH+1); PNW = $clog2(PUSH_CHANNEL+1); QNW = $clog2(POP_CHANNEL+1); OW = max(1, $clog2(PUSH_CHANNEL)).
REQ-006 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all contents this cycle
- stall  in  1  freeze; no push or pop takes effect
- data_push  in  PUSH_CHANNEL x DATA_WIDTH  push lanes
- push_num  in  PNW  entries requested to push
- push_offset  in  OW  lane of the first pushed entry
- push_accept  out  PNW  entries actually accepted this cycle
- data_pop  out  POP_CHANNEL x DATA_WIDTH  head window, oldest in lane 0
- pop_valid  out  POP_CHANNEL  per-lane valid for data_pop
- pop_num  in  QNW  entries consumed this cycle
- count  out  CW  current occupancy
- free  out  CW  DEPTH minus count
- full  out  1  count equals DEPTH
- almost_full  out  1  free is less than PUSH_CHANNEL
- empty  out  1  count equals 0

Function
REQ-007 Storage is a circular buffer of DEPTH entries with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-008 data_pop[i] = entry at (head+i) mod DEPTH; pop_valid[i] = (i < count); both are combinational from state.
REQ-009 data_pop lanes with pop_valid low carry don't-care values.
REQ-010 Pushed entry k (k < push_accept) is data_push[(push_offset+k) mod PUSH_CHANNEL] and is written at (tail+k) mod DEPTH.
REQ-011 push_accept = min(push_num, free, PUSH_CHANNEL) when flush and stall are low, else 0; it is combinational and allows partial acceptance.
REQ-012 Effective pop = min(pop_num, count, POP_CHANNEL) when flush and stall are low, else 0; excess pop_num is ignored silently.
REQ-013 On the rising edge: head += effective pop; tail += push_accept; count += push_accept - effective pop.
REQ-014 Push acceptance uses the pre-edge free value; slots vacated by a same-cycle pop are not reusable until the next cycle.
REQ-015 Latency: an entry pushed at edge N is visible on data_pop, with pop_valid high, from just after edge N; there is no bypass to the same cycle.
REQ-016 flush (synchronous) has priority over stall, push and pop: at the next edge head = tail = count = 0, and no entry is written.
REQ-017 stall with flush low holds all state; push_accept reads 0.
REQ-018 full, almost_full, empty, count and free are derived combinationally from count alone.
REQ-019 A push_num of 0 or pop_num of 0 is a legal no-op; a push_offset of PUSH_CHANNEL or greater is taken modulo PUSH_CHANNEL.

Reset
REQ-020 rst_n low asynchronously clears head, tail and count; outputs then read count=0, free=DEPTH, empty=1, full=0, almost_full=0, pop_valid=0, push_accept=0.
REQ-021 Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge; storage RAM contents are not reset.
REQ-022 Once rst_n is released, the first edge follows REQ-011 to REQ-016 normally.

Verification (DATA_WIDTH=8, DEPTH=8, PUSH_CHANNEL=4, POP_CHANNEL=4, data_push={1,2,3,4})
REQ-023 Push 1 with offset 2, then push 2 with offset 0, then push 3 with offset 0 -> pop window reads {3,1,2,1}, count=6, free=2, almost_full=1.
REQ-024 From REQ-023 state, push 4 with offset 0 -> push_accept=2, count=8, full=1; then pop 3 -> window {1,2,3,1}, count=5.
REQ-025 count=8 with pop_num=4 and push_num=4 in the same cycle -> push_accept=0, count=4 after the edge; next cycle push 4 -> accepted 4, pointers wrap correctly.
REQ-026 count=5 with pop_num=4 and stall=1 -> no change; then flush=1 together with push_num=2 -> count=0, empty=1, push_accept=0.
REQ-027 count=3, pop_num=4 -> effective pop 3, empty=1, pop_valid=0000.
REQ-028 rst_n pulsed low between edges while count=6 -> count=0 immediately; after release, push 2 -> window {1,2,-,-}.

Source files
------------

// File: rtl/multi_queue_credit_if.sv
// Bundles the push/pop handshake and occupancy status of multi_queue_credit.
interface multi_queue_credit_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PUSH_CHANNEL = 4,
    parameter int unsigned POP_CHANNEL  = 4
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PNW = $clog2(PUSH_CHANNEL + 1);
    localparam int unsigned QNW = $clog2(POP_CHANNEL + 1);
    localparam int unsigned OW  = (PUSH_CHANNEL > 1) ? $clog2(PUSH_CHANNEL) : 1;

    logic                                   flush;
    logic                                   stall;
    logic [PUSH_CHANNEL-1:0][DATA_WIDTH-1:0] data_push;
    logic [PNW-1:0]                         push_num;
    logic [OW-1:0]                          push_offset;
    logic [PNW-1:0]                         push_accept;
    logic [POP_CHANNEL-1:0][DATA_WIDTH-1:0]  data_pop;
    logic [POP_CHANNEL-1:0]                 pop_valid;
    logic [QNW-1:0]                         pop_num;
    logic [CW-1:0]                          count;
    logic [CW-1:0]                          free;
    logic                                   full;
    logic                                   almost_full;
    logic                                   empty;

    modport master (
        output flush, stall, data_push, push_num, push_offset, pop_num,
        input  push_accept, data_pop, pop_valid, count, free, full, almost_full, empty
    );

    modport slave (
        input  flush, stall, data_push, push_num, push_offset, pop_num,
        output push_accept, data_pop, pop_valid, count, free, full, almost_full, empty
    );
endinterface

// File: rtl/multi_queue_credit.sv
// Multi-lane circular queue: up to PUSH_CHANNEL entries in and POP_CHANNEL out per cycle,
// with a combinational head window and occupancy flags.
module multi_queue_credit #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PUSH_CHANNEL = 4,
    parameter int unsigned POP_CHANNEL  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_queue_credit_if.slave q
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PNW = $clog2(PUSH_CHANNEL + 1);
    localparam int unsigned QNW = $clog2(POP_CHANNEL + 1);
    localparam int unsigned OW  = (PUSH_CHANNEL > 1) ? $clog2(PUSH_CHANNEL) : 1;
    localparam int unsigned SW  = CW + PNW + QNW;

    logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d, free_c;
    logic [SW-1:0]         push_acc_c, pop_eff_c;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PUSH_CHANNEL-1:0] wr_en_c;
    logic [AW-1:0]           wr_addr_c [PUSH_CHANNEL];
    logic [DATA_WIDTH-1:0]   wr_data_c [PUSH_CHANNEL];

    assign free_c = CW'(DEPTH) - count_q;

    // Clamp requests against pre-edge occupancy and lane limits
    always_comb begin : clamp
        logic [SW-1:0] lim;
        lim        = '0;
        push_acc_c = '0;
        pop_eff_c  = '0;
        if (!q.flush && !q.stall) begin
            lim        = (SW'(free_c) < SW'(PUSH_CHANNEL)) ? SW'(free_c) : SW'(PUSH_CHANNEL);
            push_acc_c = (SW'(q.push_num) < lim) ? SW'(q.push_num) : lim;
            lim        = (SW'(count_q) < SW'(POP_CHANNEL)) ? SW'(count_q) : SW'(POP_CHANNEL);
            pop_eff_c  = (SW'(q.pop_num) < lim) ? SW'(q.pop_num) : lim;
        end
    end

    always_comb begin : next_state
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_eff_c);
            tail_d  = tail_q + AW'(push_acc_c);
            count_d = count_q + CW'(push_acc_c) - CW'(pop_eff_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Lane k of the accepted group rotates from push_offset and lands at tail+k
    always_comb begin : write_map
        for (int unsigned k = 0; k < PUSH_CHANNEL; k++) begin
            wr_en_c[k]   = SW'(k) < push_acc_c;
            wr_addr_c[k] = tail_q + AW'(k);
            wr_data_c[k] = q.data_push[OW'((32'(q.push_offset) + k) % PUSH_CHANNEL)];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < PUSH_CHANNEL; k++) begin
            if (wr_en_c[k]) mem_q[wr_addr_c[k]] <= wr_data_c[k];
        end
    end

    always_comb begin : head_window
        for (int unsigned i = 0; i < POP_CHANNEL; i++) begin
            q.data_pop[i]  = mem_q[head_q + AW'(i)];
            q.pop_valid[i] = CW'(i) < count_q;
        end
    end

    assign q.push_accept = PNW'(push_acc_c);
    assign q.count       = count_q;
    assign q.free        = free_c;
    assign q.full        = count_q == CW'(DEPTH);
    assign q.almost_full = free_c < CW'(PUSH_CHANNEL);
    assign q.empty       = count_q == '0;
endmodule

// File: tb/tb_multi_queue_credit.sv
// Directed and randomized bench for multi_queue_credit against a queue-based reference model.
module tb_multi_queue_credit;
    localparam int unsigned DW = 8, DEPTH = 8, PC = 4, QC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_queue_credit_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_CHANNEL(PC), .POP_CHANNEL(QC)) q ();
    multi_queue_credit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_CHANNEL(PC), .POP_CHANNEL(QC))
        dut (.clk(clk), .rst_n(rst_n), .q(q));

    logic [7:0]  model_q [$];
    logic [7:0]  lanes [PC];
    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        chk_cnt++;
        if (obs === want) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    endtask

    task automatic drive_lanes();
        for (int k = 0; k < PC; k++) q.data_push[k] = lanes[k];
    endtask

    task automatic idle();
        q.flush = 1'b0; q.stall = 1'b0;
        q.push_num = '0; q.push_offset = '0; q.pop_num = '0;
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        check("count", 64'(q.count), 64'(n));
        check("free", 64'(q.free), 64'(DEPTH - n));
        check("full", 64'(q.full), 64'(n == DEPTH));
        check("almost_full", 64'(q.almost_full), 64'((DEPTH - n) < PC));
        check("empty", 64'(q.empty), 64'(n == 0));
        for (int i = 0; i < QC; i++) begin
            check("pop_valid", 64'(q.pop_valid[i]), 64'(i < n));
            if (i < n) check("data_pop", 64'(q.data_pop[i]), 64'(model_q[i]));
        end
    endtask

    // Called at a falling edge; applies inputs for one rising edge and checks the result
    task automatic cycle(input bit f, input bit s, input int pn, input int po, input int qn);
        int n, acc, pop;
        q.flush = f; q.stall = s;
        q.push_num = 3'(pn); q.push_offset = 2'(po); q.pop_num = 3'(qn);
        drive_lanes();
        #1;
        n = model_q.size();
        acc = 0; pop = 0;
        if (!f && !s) begin
            acc = pn;
            if (acc > DEPTH - n) acc = DEPTH - n;
            if (acc > PC) acc = PC;
            pop = qn;
            if (pop > n) pop = n;
            if (pop > QC) pop = QC;
        end
        check("push_accept", 64'(q.push_accept), 64'(acc));
        @(posedge clk);
        if (f) model_q.delete();
        else begin
            repeat (pop) void'(model_q.pop_front());
            for (int k = 0; k < acc; k++) model_q.push_back(lanes[(po + k) % PC]);
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < PC; k++) lanes[k] = 8'(k + 1);
        drive_lanes();
        idle();
        #12;
        check_state();
        check("reset_push_accept", 64'(q.push_accept), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        cycle(0, 0, 1, 2, 0);
        cycle(0, 0, 2, 0, 0);
        cycle(0, 0, 3, 0, 0);
        check("win23_0", 64'(q.data_pop[0]), 64'd3);
        check("win23_1", 64'(q.data_pop[1]), 64'd1);
        check("win23_2", 64'(q.data_pop[2]), 64'd2);
        check("win23_3", 64'(q.data_pop[3]), 64'd1);
        check("cnt23", 64'(q.count), 64'd6);

        cycle(0, 0, 4, 0, 0);
        check("full24", 64'(q.full), 64'd1);
        cycle(0, 0, 0, 0, 3);
        check("win24_0", 64'(q.data_pop[0]), 64'd1);
        check("win24_1", 64'(q.data_pop[1]), 64'd2);
        check("win24_2", 64'(q.data_pop[2]), 64'd3);
        check("win24_3", 64'(q.data_pop[3]), 64'd1);

        cycle(0, 0, 3, 0, 0);
        cycle(0, 0, 4, 0, 4);
        check("cnt25a", 64'(q.count), 64'd4);
        cycle(0, 0, 4, 1, 0);
        check("cnt25b", 64'(q.count), 64'd8);

        cycle(0, 0, 0, 0, 3);
        cycle(0, 1, 3, 0, 4);
        cycle(1, 0, 2, 0, 0);
        check("empty26", 64'(q.empty), 64'd1);

        cycle(0, 0, 3, 3, 0);
        cycle(0, 0, 0, 0, 4);
        check("pv27", 64'(q.pop_valid), 64'd0);

        cycle(0, 0, 4, 0, 0);
        cycle(0, 0, 2, 0, 0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check_state();
        check("rst_push_accept", 64'(q.push_accept), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cycle(0, 0, 2, 0, 0);
        check("win28_0", 64'(q.data_pop[0]), 64'd1);
        check("win28_1", 64'(q.data_pop[1]), 64'd2);

        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < PC; k++) lanes[k] = 8'($urandom);
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
